sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream consumer of the 4-bit parallel adder stage.
- Captures each 5-bit adder result {c_out, sum[3:0]} through a valid/ready handshake and accumulates COUNT results into a block total.
- Presents the total on a registered, held output handshake; a sticky flag reports accumulator wrap.
- Feeds block sums to the next datapath/display stage.

Parameters:
- ACC_W, 8: accumulator and out_total width in bits (must be >= 5).
- COUNT, 16: results per block (must be >= 2).
- CNT_W, $clog2(COUNT+1): sample counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  adder result present.
- in_ready  output  1  block can accept a result this cycle.
- in_sum  input  4  adder sum[3:0].
- in_cout  input  1  adder carry-out.
- clear  input  1  synchronous abort/flush, active-high.
- out_valid  output  1  block total available.
- out_ready  input  1  downstream accepts total.
- out_total  output  ACC_W  block total, mod 2^ACC_W.
- out_ovf  output  1  total wrapped during this block.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, acc=0, cnt=0, out_total=0, out_ovf=0, out_valid=0.
- Sample value: v = {in_cout, in_sum}, unsigned 0..31, zero-extended to ACC_W+1 bits for the add.
- Accept condition: accept = in_valid && in_ready.
- in_ready is combinational: (state != HOLD) && !clear. It never depends on in_valid.
- Add rule: nxt = acc + v, computed at ACC_W+1 bits. The stored value is nxt[ACC_W-1:0]. Bit nxt[ACC_W] set marks a wrap, which ORs into a sticky ovf_acc bit.
- IDLE:
  - On accept: acc<=v, cnt<=1, ovf_acc<=0, go to ACCUM.
  - No accept: hold.
- ACCUM, on accept:
  - If cnt < COUNT-1: acc<=nxt, cnt<=cnt+1.
  - If cnt == COUNT-1 (final sample): out_total<=nxt[ACC_W-1:0], out_ovf<=ovf_acc|nxt[ACC_W], out_valid<=1, acc<=0, cnt<=0, go to HOLD.
- ACCUM, no accept: hold all state; gaps in in_valid are allowed.
- HOLD:
  - in_ready=0.
  - out_total and out_ovf stay stable while out_valid=1.
  - On out_valid && out_ready: out_valid<=0, go to IDLE. The next sample can be accepted on the following cycle.
- Latency: out_valid rises on the clock edge that accepts the final sample, so it is visible the cycle after that sample is presented.
- Throughput: COUNT cycles plus at least 1 HOLD cycle per block.
- clear has priority over everything, in any state:
  - acc<=0, cnt<=0, ovf_acc<=0, out_valid<=0, out_ovf<=0, state<=IDLE.
  - out_total keeps its last value.
  - A sample offered in the same cycle is not accepted (in_ready is low).
- Reset mid-block: immediate return to reset values; the partial block is discarded.
- busy = (state != IDLE).

Decomposition:
- Shared package sum_acc_pkg holds:
  - state encoding: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2; the unused code 2'd3 recovers to IDLE.
  - localparam SAMPLE_W=5.
- One natural sub-module, sample_counter: a CNT_W counter with inc, clr and terminal (cnt==COUNT-1) outputs.
- The accumulator register, adder and FSM stay in the top module.

Test Plan:
- Basic block: 16 back-to-back samples of in_sum=1, in_cout=0, out_ready=1 → out_valid for exactly 1 cycle; out_total=16, out_ovf=0; in_ready low during that cycle.
- Overflow: 16 samples of in_sum=15, in_cout=1 (v=31), total 496 → out_total=240, out_ovf=1. Next block of 16×1 → out_total=16, out_ovf=0 (flag does not carry over).
- Backpressure: complete a block with out_ready=0 for 5 cycles → out_valid and out_total held stable and in_ready=0 throughout. Raise out_ready → handshake completes, IDLE next cycle.
- Input gaps: 16 samples of v=3 with in_valid toggled on alternate cycles → out_total=48, out_valid only after the 16th accept.
- Clear mid-block: after 7 samples of v=5, assert clear with in_valid=1 → sample not accepted, busy=0. Then 16×2 → out_total=32.
- Async reset: drop rst_n mid-block and while in HOLD → all outputs return to reset values immediately, without waiting for a clk edge. After release, a full block yields the correct total.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum_accumulator block: FSM state encoding and
// the width of one adder result sample.
package sum_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int SAMPLE_W = 5;

endpackage

// File: rtl/sum_accumulator_sample_counter.sv
// Sample counter for sum_accumulator: counts accepted samples in a block and
// flags the slot holding the final sample of the block.
module sample_counter #(
   parameter int COUNT = 16,
   parameter int CNT_W = $clog2(COUNT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic terminal
);

   logic [CNT_W-1:0] cnt;

   // clr wins over inc so a block can end and restart the count in one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign terminal = (cnt == CNT_W'(COUNT - 1));

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT 5-bit adder results into a block total and presents the
// total on a held valid/ready output with a sticky wrap flag.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int ACC_W = 8,
   parameter int COUNT = 16,
   parameter int CNT_W = $clog2(COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_sum,
   input  logic             in_cout,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic             out_ovf,
   output logic             busy
);

   state_t              state;
   state_t              state_nxt;
   logic [ACC_W-1:0]    acc;
   logic                ovf_acc;
   logic [SAMPLE_W-1:0] v;
   logic [ACC_W:0]      nxt;
   logic                accept;
   logic                terminal;
   logic                final_accept;
   logic                cnt_clr;

   assign v            = {in_cout, in_sum};
   assign nxt          = {1'b0, acc} + (ACC_W + 1)'(v);
   assign in_ready     = (state != HOLD) && !clear;
   assign accept       = in_valid && in_ready;
   assign final_accept = (state == ACCUM) && accept && terminal;
   assign cnt_clr      = clear || final_accept;
   assign busy         = (state != IDLE);

   sample_counter #(
      .COUNT (COUNT),
      .CNT_W (CNT_W)
   ) u_sample_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (accept),
      .clr      (cnt_clr),
      .terminal (terminal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Unused encoding falls back to IDLE; clear forces IDLE from anywhere
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ACCUM;
         ACCUM:   if (final_accept) state_nxt = HOLD;
         HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clear) begin
         state_nxt = IDLE;
      end
   end

   // out_total deliberately survives clear so the last block stays readable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         ovf_acc   <= 1'b0;
         out_total <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else if (clear) begin
         acc       <= '0;
         ovf_acc   <= 1'b0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc     <= ACC_W'(v);
                  ovf_acc <= 1'b0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  if (terminal) begin
                     out_total <= nxt[ACC_W-1:0];
                     out_ovf   <= ovf_acc | nxt[ACC_W];
                     out_valid <= 1'b1;
                     acc       <= '0;
                     ovf_acc   <= 1'b0;
                  end else begin
                     acc     <= nxt[ACC_W-1:0];
                     ovf_acc <= ovf_acc | nxt[ACC_W];
                  end
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               acc     <= '0;
               ovf_acc <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator with default parameters
// (ACC_W=8, COUNT=16).
module tb_sum_accumulator;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_sum;
   logic       in_cout;
   logic       clear;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_total;
   logic       out_ovf;
   logic       busy;

   int total;
   int bad;

   sum_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_cout   (in_cout),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_total (out_total),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offers one sample for exactly one rising edge; returns 1 time unit after it
   task automatic drive_sample(input logic [4:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      {in_cout, in_sum} = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drive_block(input logic [4:0] v, input int n);
      for (int i = 0; i < n; i++) drive_sample(v);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      total++;
      if (out_valid !== 1'b0 || out_total !== 8'd0 || out_ovf !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_values: valid=%b total=%0d ovf=%b busy=%b, want 0 0 0 0",
                  out_valid, out_total, out_ovf, busy);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      drive_block(5'd1, 15);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_before_final: valid=%b busy=%b, want 0 1", out_valid, busy);
      end
      drive_sample(5'd1);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd16 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_result: valid=%b total=%0d ovf=%b ready=%b, want 1 16 0 0",
                  out_valid, out_total, out_ovf, in_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_one_cycle: valid=%b busy=%b ready=%b, want 0 0 1",
                  out_valid, busy, in_ready);
      end
   endtask

   task automatic test_overflow;
      out_ready = 1'b1;
      drive_block(5'd31, 16);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd240 || out_ovf !== 1'b1) begin
         bad++;
         $display("[TB] FAIL overflow_result: valid=%b total=%0d ovf=%b, want 1 240 1",
                  out_valid, out_total, out_ovf);
      end
      @(posedge clk);
      #1;
      drive_block(5'd1, 16);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd16 || out_ovf !== 1'b0) begin
         bad++;
         $display("[TB] FAIL overflow_not_sticky: valid=%b total=%0d ovf=%b, want 1 16 0",
                  out_valid, out_total, out_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      drive_block(5'd2, 16);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || out_total !== 8'd32 || in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL backpressure_hold[%0d]: valid=%b total=%0d ready=%b busy=%b, want 1 32 0 1",
                     i, out_valid, out_total, in_ready, busy);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_total !== 8'd32) begin
         bad++;
         $display("[TB] FAIL backpressure_release: valid=%b busy=%b total=%0d, want 0 0 32",
                  out_valid, busy, out_total);
      end
   endtask

   task automatic test_gaps;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         drive_sample(5'd3);
         @(posedge clk);
         #1;
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL gaps_early_valid: got %b want 0", out_valid);
      end
      drive_sample(5'd3);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd48 || out_ovf !== 1'b0) begin
         bad++;
         $display("[TB] FAIL gaps_result: valid=%b total=%0d ovf=%b, want 1 48 0",
                  out_valid, out_total, out_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clear;
      out_ready = 1'b1;
      drive_block(5'd5, 7);
      @(negedge clk);
      in_valid = 1'b1;
      {in_cout, in_sum} = 5'd5;
      clear = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL clear_in_ready: got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_total !== 8'd48) begin
         bad++;
         $display("[TB] FAIL clear_state: busy=%b valid=%b total=%0d, want 0 0 48",
                  busy, out_valid, out_total);
      end
      drive_block(5'd2, 16);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd32 || out_ovf !== 1'b0) begin
         bad++;
         $display("[TB] FAIL clear_next_block: valid=%b total=%0d ovf=%b, want 1 32 0",
                  out_valid, out_total, out_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset;
      out_ready = 1'b1;
      drive_block(5'd9, 5);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_total !== 8'd0) begin
         bad++;
         $display("[TB] FAIL async_reset_accum: busy=%b valid=%b total=%0d, want 0 0 0",
                  busy, out_valid, out_total);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b0;
      drive_block(5'd31, 16);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd240 || out_ovf !== 1'b1) begin
         bad++;
         $display("[TB] FAIL async_reset_pre_hold: valid=%b total=%0d ovf=%b, want 1 240 1",
                  out_valid, out_total, out_ovf);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_total !== 8'd0 || out_ovf !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset_hold: valid=%b total=%0d ovf=%b busy=%b, want 0 0 0 0",
                  out_valid, out_total, out_ovf, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive_block(5'd7, 16);
      total++;
      if (out_valid !== 1'b1 || out_total !== 8'd112 || out_ovf !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset_recover: valid=%b total=%0d ovf=%b, want 1 112 0",
                  out_valid, out_total, out_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b1;
      in_valid = 1'b0;
      in_sum = 4'd0;
      in_cout = 1'b0;
      clear = 1'b0;
      out_ready = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_gaps();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
